// File: rtl/iobus_pkg.sv
// rtl/iobus_pkg.sv - shared I/O bus address map, TCTRL field positions and register-select decode
package iobus_pkg;

    // Word addresses decoded on the I/O bus; anything else reads 0 and ignores writes.
    localparam logic [31:0] ADDR_SW     = 32'h1100_0000;
    localparam logic [31:0] ADDR_LED    = 32'h1100_0020;
    localparam logic [31:0] ADDR_TCTRL  = 32'h1100_0100;
    localparam logic [31:0] ADDR_TCOUNT = 32'h1100_0104;
    localparam logic [31:0] ADDR_TCMP   = 32'h1100_0108;
    localparam logic [31:0] ADDR_TSTAT  = 32'h1100_010C;

    // TCTRL field positions
    localparam int TCTRL_EN_BIT = 0;
    localparam int TCTRL_AR_BIT = 1;
    localparam int TCTRL_IE_BIT = 2;
    localparam int TCTRL_PS_LSB = 8;
    localparam int TCTRL_PS_MSB = 15;

    typedef enum logic [2:0] {
        SEL_NONE   = 3'd0,
        SEL_SW     = 3'd1,
        SEL_LED    = 3'd2,
        SEL_TCTRL  = 3'd3,
        SEL_TCOUNT = 3'd4,
        SEL_TCMP   = 3'd5,
        SEL_TSTAT  = 3'd6
    } reg_sel_e;

    // Exact word match only: aliases and misaligned byte addresses fall to SEL_NONE.
    function automatic reg_sel_e addr_decode(input logic [31:0] addr);
        case (addr)
            ADDR_SW:     return SEL_SW;
            ADDR_LED:    return SEL_LED;
            ADDR_TCTRL:  return SEL_TCTRL;
            ADDR_TCOUNT: return SEL_TCOUNT;
            ADDR_TCMP:   return SEL_TCMP;
            ADDR_TSTAT:  return SEL_TSTAT;
            default:     return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/io_timer.sv
// rtl/io_timer.sv - prescaled 32-bit timer with compare, sticky MATCH flag and interrupt
// Ports:
//   CLK, RST_N      clock, synchronous active-low reset
//   wr, sel, wdata  register write strobe, decoded register select, write data
//   tctrl           TCTRL read value (EN, AUTORELOAD, IE, PRESCALE; other bits 0)
//   tcount, tcmp    counter and compare registers
//   match           sticky MATCH flag (TSTAT bit0)
//   intr            MATCH AND IE
module io_timer
    import iobus_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        wr,
    input  reg_sel_e    sel,
    input  logic [31:0] wdata,
    output logic [31:0] tctrl,
    output logic [31:0] tcount,
    output logic [31:0] tcmp,
    output logic        match,
    output logic        intr
);

    logic       ctrl_en;
    logic       ctrl_ar;
    logic       ctrl_ie;
    logic [7:0] ctrl_ps;
    logic [7:0] presc;
    logic [31:0] count_q;
    logic [31:0] cmp_q;
    logic        match_q;

    logic wr_ctrl;
    logic wr_count;
    logic wr_cmp;
    logic clr_match;
    logic tick;
    logic hit;

    assign wr_ctrl   = wr && (sel == SEL_TCTRL);
    assign wr_count  = wr && (sel == SEL_TCOUNT);
    assign wr_cmp    = wr && (sel == SEL_TCMP);
    assign clr_match = wr && (sel == SEL_TSTAT) && wdata[0];

    // PRESCALE=0 makes the prescaler sit at 0 and tick every enabled cycle.
    assign tick = ctrl_en && (presc == ctrl_ps);
    assign hit  = tick && (count_q == cmp_q);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ctrl_en <= 1'b0;
            ctrl_ar <= 1'b0;
            ctrl_ie <= 1'b0;
            ctrl_ps <= '0;
            presc   <= '0;
            count_q <= '0;
            cmp_q   <= '0;
            match_q <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en <= wdata[TCTRL_EN_BIT];
                ctrl_ar <= wdata[TCTRL_AR_BIT];
                ctrl_ie <= wdata[TCTRL_IE_BIT];
                ctrl_ps <= wdata[TCTRL_PS_MSB:TCTRL_PS_LSB];
            end

            // Any TCTRL write restarts the prescale period from 0.
            if (wr_ctrl || tick) begin
                presc <= '0;
            end else if (ctrl_en) begin
                presc <= presc + 8'd1;
            end

            if (wr_cmp) begin
                cmp_q <= wdata;
            end

            // CPU write beats the tick update in the same cycle.
            if (wr_count) begin
                count_q <= wdata;
            end else if (hit && ctrl_ar) begin
                count_q <= '0;
            end else if (tick) begin
                count_q <= count_q + 32'd1;
            end

            // A match set in the same cycle as a W1C wins.
            if (hit) begin
                match_q <= 1'b1;
            end else if (clr_match) begin
                match_q <= 1'b0;
            end
        end
    end

    assign tctrl  = {16'b0, ctrl_ps, 5'b0, ctrl_ie, ctrl_ar, ctrl_en};
    assign tcount = count_q;
    assign tcmp   = cmp_q;
    assign match  = match_q;
    assign intr   = match_q && ctrl_ie;

endmodule

// File: rtl/iobus_periph.sv
// rtl/iobus_periph.sv - CPU I/O bus peripheral: switches, LEDs and optional timer (OTTER_IO_TIMER_EN)
// Ports:
//   CLK, RST_N   clock, synchronous active-low reset
//   IOBUS_ADDR   byte address from CPU
//   IOBUS_OUT    write data from CPU
//   IOBUS_WR     one-cycle write strobe
//   IOBUS_IN     combinational read data to CPU
//   SWITCHES     asynchronous board switches (2-flop synchronized)
//   LEDS         LED register contents
//   INTR         timer interrupt (0 when OTTER_IO_TIMER_EN is undefined)
module iobus_periph
    import iobus_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    input  logic [15:0] SWITCHES,
    output logic [15:0] LEDS,
    output logic        INTR
);

    reg_sel_e    sel;
    logic [15:0] sw_meta;
    logic [15:0] sw_sync;
    logic [15:0] led_q;

    assign sel = addr_decode(IOBUS_ADDR);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sw_meta <= '0;
            sw_sync <= '0;
            led_q   <= '0;
        end else begin
            sw_meta <= SWITCHES;
            sw_sync <= sw_meta;
            if (IOBUS_WR && (sel == SEL_LED)) begin
                led_q <= IOBUS_OUT[15:0];
            end
        end
    end

    assign LEDS = led_q;

`ifdef OTTER_IO_TIMER_EN
    logic [31:0] tmr_tctrl;
    logic [31:0] tmr_tcount;
    logic [31:0] tmr_tcmp;
    logic        tmr_match;

    io_timer u_timer (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .wr     (IOBUS_WR),
        .sel    (sel),
        .wdata  (IOBUS_OUT),
        .tctrl  (tmr_tctrl),
        .tcount (tmr_tcount),
        .tcmp   (tmr_tcmp),
        .match  (tmr_match),
        .intr   (INTR)
    );

    always_comb begin
        IOBUS_IN = '0;
        case (sel)
            SEL_SW:     IOBUS_IN = {16'b0, sw_sync};
            SEL_LED:    IOBUS_IN = {16'b0, led_q};
            SEL_TCTRL:  IOBUS_IN = tmr_tctrl;
            SEL_TCOUNT: IOBUS_IN = tmr_tcount;
            SEL_TCMP:   IOBUS_IN = tmr_tcmp;
            SEL_TSTAT:  IOBUS_IN = {31'b0, tmr_match};
            default:    IOBUS_IN = '0;
        endcase
    end
`else
    // Without the timer only the LED bits of the write data are consumed.
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^IOBUS_OUT[31:16];

    assign INTR = 1'b0;

    always_comb begin
        IOBUS_IN = '0;
        case (sel)
            SEL_SW:  IOBUS_IN = {16'b0, sw_sync};
            SEL_LED: IOBUS_IN = {16'b0, led_q};
            default: IOBUS_IN = '0;
        endcase
    end
`endif

endmodule
